multicycle_ctrl: RTL

- Main FSM controller for the multi-cycle RV32I core variant. It sequences the shared PC/IR, the register file (ID stage), the ALU and a single unified memory port across FETCH/DECODE/EXEC/MEM/WB states.
- Decodes the opcode latched from the IR and drives per-state control strobes.
- Handles memory wait-states via the mem_ready handshake.
- Flags illegal opcodes and memory timeouts.

---
 rtl/multicycle_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I main control FSM with memory wait/timeout handling
// Optional performance counters are built when MULTICYCLE_PERF_CNT_EN is defined.
module multicycle_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             zero,
    output logic [2:0]       state,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             result_src,
    output logic             retire,
    output logic             illegal,
    output logic             err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam int          TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

    state_t        state_q, state_d;
    logic [6:0]    op_q;
    logic [TW-1:0] to_cnt;
    logic          err_q;
    logic          waiting, timeout_hit, dec_legal;
    logic          is_r, is_i, is_lw, is_sw, is_beq;
    state_t        boundary;

    assign is_r   = (op_q == OP_R);
    assign is_i   = (op_q == OP_IALU);
    assign is_lw  = (op_q == OP_LW);
    assign is_sw  = (op_q == OP_SW);
    assign is_beq = (op_q == OP_BEQ);

    // DECODE judges the live opcode; the latch only becomes valid from EXEC on.
    assign dec_legal = (opcode == OP_R) || (opcode == OP_IALU) || (opcode == OP_LW) ||
                       (opcode == OP_SW) || (opcode == OP_BEQ);

    assign waiting     = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;
    assign timeout_hit = ((state_q == FETCH) || (state_q == MEM)) && (to_cnt == TO_MAX);
    assign boundary    = en ? FETCH : IDLE;

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        result_src = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            IDLE: if (en) state_d = FETCH;
            FETCH: begin
                if (timeout_hit) begin
                    state_d = HALT;
                end else begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end
                end
            end
            DECODE: begin
                if (dec_legal) begin
                    state_d = EXEC;
                end else begin
                    illegal = 1'b1;
                    state_d = boundary;
                end
            end
            EXEC: begin
                alu_src = is_i || is_lw || is_sw;
                alu_op  = (is_r || is_i) ? 2'b10 : (is_beq ? 2'b01 : 2'b00);
                if (is_r || is_i) begin
                    state_d = WB;
                end else if (is_lw || is_sw) begin
                    state_d = MEM;
                end else begin
                    pc_write = is_beq && zero;
                    pc_src   = is_beq;
                    retire   = is_beq;
                    state_d  = boundary;
                end
            end
            MEM: begin
                if (timeout_hit) begin
                    state_d = HALT;
                end else begin
                    iord = 1'b1;
                    if (is_lw) begin
                        mem_read = 1'b1;
                        if (mem_ready) state_d = WB;
                    end else begin
                        mem_write = 1'b1;
                        if (mem_ready) begin
                            retire  = 1'b1;
                            state_d = boundary;
                        end
                    end
                end
            end
            WB: begin
                reg_write  = 1'b1;
                result_src = is_lw;
                retire     = 1'b1;
                state_d    = boundary;
            end
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= 7'd0;
            to_cnt  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) op_q <= opcode;
            if (state_d != state_q) to_cnt <= '0;
            else if (waiting)       to_cnt <= to_cnt + TW'(1);
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    assign state = state_q;
    assign err   = err_q;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ret_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_q <= '0;
            ret_q <= '0;
        end else begin
            if ((state_q != IDLE) && (state_q != HALT)) cyc_q <= cyc_q + CNT_W'(1);
            if (retire) ret_q <= ret_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cyc_q;
    assign instret_cnt = ret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
